vga_timing_generator: RTL and testbench

- Produces the raster scan consumed by the sprite/background renderers: DrawX, DrawY, blank, plus sync pulses for the VGA DAC/connector.
- Sits between the pixel clock source and every renderer in the display path; it is the single source of screen coordinates.
- Default timing is 640x480 @ 60 Hz, 800x525 total, with a 25 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_wrap_counter.sv | 50 +++++
 rtl/vga_timing_generator.sv | 145 ++++++++++++++
 tb/tb_vga_timing_generator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA display path.
// Defaults describe 640x480 @ 60 Hz (800x525 total, 25 MHz pixel clock).
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // Half-open window test [lo, hi) used for the sync pulse decode.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// 10-bit raster counter that wraps at MAX, with a registered one-cycle wrap pulse.
// count_next exposes the value the counter loads at the coming edge.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned MAX = H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   at_max,
  output logic   wrap
);

  localparam coord_t MAX_C = coord_t'(MAX);

  coord_t count_q, count_d;
  logic   wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (count_q == MAX_C) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign at_max     = (count_q == MAX_C);
  assign wrap       = wrap_q;

endmodule

// File: rtl/vga_timing_generator.sv
// Raster scan generator: screen coordinates, blank, active-low syncs and frame pulses.
// Define VGA_SYNC_DELAY_EN to delay hs/vs/blank by one pixel for registered-colour renderers.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t VIS_X = coord_t'(H_VISIBLE);
  localparam coord_t VIS_Y = coord_t'(V_VISIBLE);
  localparam coord_t HS_LO = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_LO = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
    $error("vga_timing_generator: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  coord_t x_next, y_next;
  logic   x_at_max, y_at_max;
  logic   x_wrap, y_wrap;

  vga_wrap_counter #(.MAX(H_TOT - 1)) u_h_cnt (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (enable),
    .count      (DrawX),
    .count_next (x_next),
    .at_max     (x_at_max),
    .wrap       (x_wrap)
  );

  // The vertical counter only moves on the cycle the horizontal one wraps.
  vga_wrap_counter #(.MAX(V_TOT - 1)) u_v_cnt (
    .clk        (vga_clk),
    .rst_n      (reset_n),
    .en         (enable && x_at_max),
    .count      (DrawY),
    .count_next (y_next),
    .at_max     (y_at_max),
    .wrap       (y_wrap)
  );

  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   blank_q, blank_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  // Decode from the next coordinates so the registered flags line up with DrawX/DrawY.
  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    frame_count_d = frame_count_q;
    if (enable) begin
      hs_d    = !in_window(x_next, HS_LO, HS_HI);
      vs_d    = !in_window(y_next, VS_LO, VS_HI);
      blank_d = (x_next < VIS_X) && (y_next < VIS_Y);
      if (x_at_max && y_at_max) begin
        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q, hs_dly_d;
  logic vs_dly_q, vs_dly_d;
  logic blank_dly_q, blank_dly_d;

  // Extra stage holds with the scan so a stall never lets the flags drift from the coordinates.
  always_comb begin
    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    blank_dly_d = blank_dly_q;
    if (enable) begin
      hs_dly_d    = hs_q;
      vs_dly_d    = vs_q;
      blank_dly_d = blank_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q    <= 1'b1;
      vs_dly_q    <= 1'b1;
      blank_dly_q <= 1'b0;
    end else begin
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      blank_dly_q <= blank_dly_d;
    end
  end

  assign hs    = hs_dly_q;
  assign vs    = vs_dly_q;
  assign blank = blank_dly_q;
`else
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`endif

  assign line_start  = x_wrap;
  assign frame_start = y_wrap;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full-size instance for line timing, reduced-timing instance for frame behaviour.
module tb_vga_timing_generator;

`ifdef VGA_SYNC_DELAY_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  // Reduced timing: 100 x 60 total, hs low x 72..87, vs low y 51..52, visible 64 x 48.
  localparam int SH_TOT = 100;
  localparam int SV_TOT = 60;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;

  logic       d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [15:0] d_fc;

  logic       s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [1:0] s_fc;

  int n_checks = 0;
  int n_errs   = 0;
  int sx = 0, sy = 0, s_pos_err = 0;

  always #5 clk = ~clk;

  vga_timing_generator u_dut (
    .vga_clk(clk), .reset_n(reset_n), .enable(enable),
    .hs(d_hs), .vs(d_vs), .blank(d_blank), .DrawX(d_x), .DrawY(d_y),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_generator #(
    .H_VISIBLE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(12),
    .V_VISIBLE(48), .V_FRONT(3), .V_SYNC(2), .V_BACK(7), .FRAME_CNT_W(2)
  ) u_small (
    .vga_clk(clk), .reset_n(reset_n), .enable(enable),
    .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock on the reduced instance, tracking its expected position.
  task automatic step_s();
    step();
    sx++;
    if (sx == SH_TOT) begin
      sx = 0;
      sy++;
      if (sy == SV_TOT) sy = 0;
    end
    if (s_x !== 10'(sx) || s_y !== 10'(sy)) s_pos_err++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ex, ey, pos_err;
    int hs_first, hs_last, hs_cnt, vs_cnt, blank_fall, blank_rise, ls_cnt, ls_x;
    int vs_first_x, vs_first_y, vs_last_y, blank_bad, fs_cnt, hold_err;
    logic prev_blank;

    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_x", d_x, 0);
    check("rst_y", d_y, 0);
    check("rst_hs", d_hs, 1);
    check("rst_vs", d_vs, 1);
    check("rst_blank", d_blank, 0);
    check("rst_ls", d_ls, 0);
    check("rst_fs", d_fs, 0);
    check("rst_fc", d_fc, 0);
    reset_n = 1'b1;

    step();
    check("first_x", d_x, 1);
    check("first_ls", d_ls, 0);
    check("first_fs", d_fs, 0);
    check("first_blank", d_blank, (L == 0) ? 1 : 0);

    // Full 800-pixel line on the default-timing instance.
    ex = 1; ey = 0; pos_err = 0;
    hs_first = -1; hs_last = -1; hs_cnt = 0; vs_cnt = 0;
    blank_fall = -1; blank_rise = -1; ls_cnt = 0; ls_x = -1;
    prev_blank = d_blank;
    for (int i = 0; i < 800; i++) begin
      step();
      ex++;
      if (ex == 800) begin ex = 0; ey++; end
      if (d_x !== 10'(ex) || d_y !== 10'(ey)) pos_err++;
      if (!d_hs) begin
        if (hs_first < 0) hs_first = ex;
        hs_last = ex;
        hs_cnt++;
      end
      if (!d_vs) vs_cnt++;
      if (ey == 0 && prev_blank && !d_blank && blank_fall < 0) blank_fall = ex;
      if (ey == 1 && !prev_blank && d_blank && blank_rise < 0) blank_rise = ex;
      if (d_ls) begin ls_cnt++; ls_x = ex; end
      prev_blank = d_blank;
    end
    check("line_pos", pos_err, 0);
    check("hs_first", hs_first, 656 + L);
    check("hs_last", hs_last, 751 + L);
    check("hs_width", hs_cnt, 96);
    check("vs_line0", vs_cnt, 0);
    check("blank_fall", blank_fall, 640 + L);
    check("blank_rise", blank_rise, L);
    check("ls_count", ls_cnt, 1);
    check("ls_at_x0", ls_x, 0);

    // Asynchronous reset between edges.
    reset_n = 1'b0;
    #1;
    check("async_x", d_x, 0);
    check("async_y", d_y, 0);
    check("async_hs", d_hs, 1);
    check("async_blank", d_blank, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // One full frame on the reduced instance.
    sx = 0; sy = 0; s_pos_err = 0;
    vs_cnt = 0; vs_first_x = -1; vs_first_y = -1; vs_last_y = -1;
    blank_bad = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < SH_TOT * SV_TOT; i++) begin
      step_s();
      if (!s_vs) begin
        if (vs_first_y < 0) begin vs_first_x = sx; vs_first_y = sy; end
        vs_last_y = sy;
        vs_cnt++;
      end
      if (s_blank && sy >= 48) blank_bad++;
      if (s_ls) ls_cnt++;
      if (s_fs) fs_cnt++;
    end
    check("frame_pos", s_pos_err, 0);
    check("frame_x0", s_x, 0);
    check("frame_y0", s_y, 0);
    check("frame_fs", s_fs, 1);
    check("frame_fs_count", fs_cnt, 1);
    check("frame_fc", s_fc, 1);
    check("frame_ls_count", ls_cnt, SV_TOT);
    check("vs_first_y", vs_first_y, 51);
    check("vs_first_x", vs_first_x, L);
    check("vs_last_y", vs_last_y, 52 + L);
    check("vs_width", vs_cnt, 2 * SH_TOT);
    check("blank_below", blank_bad, 0);

    // Stall exactly on the frame wrap.
    for (int i = 0; i < SH_TOT * SV_TOT - 1; i++) step_s();
    check("stall_pos_x", s_x, 99);
    check("stall_pos_y", s_y, 59);
    enable = 1'b0;
    hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_x !== 10'd99 || s_y !== 10'd59 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
          s_blank !== 1'b0 || s_fs !== 1'b0 || s_ls !== 1'b0 || s_fc !== 2'd1) hold_err++;
    end
    check("stall_hold", hold_err, 0);
    enable = 1'b1;
    step_s();
    check("resume_x", s_x, 0);
    check("resume_y", s_y, 0);
    check("resume_fs", s_fs, 1);
    check("resume_fc", s_fc, 2);
    step_s();
    check("resume_fs_drop", s_fs, 0);
    check("resume_x1", s_x, 1);

    // Frame counter wrap 3 -> 0.
    for (int i = 0; i < SH_TOT * SV_TOT - 1; i++) step_s();
    check("fc_three", s_fc, 3);
    for (int i = 0; i < SH_TOT * SV_TOT; i++) step_s();
    check("fc_wrap", s_fc, 0);
    check("fc_wrap_fs", s_fs, 1);

    // Mid-frame reset at (30,20).
    for (int i = 0; i < 20 * SH_TOT + 30; i++) step_s();
    check("mid_pos", s_pos_err, 0);
    check("mid_x", s_x, 30);
    check("mid_blank", s_blank, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_x", s_x, 0);
    check("mid_rst_y", s_y, 0);
    check("mid_rst_fc", s_fc, 0);
    check("mid_rst_blank", s_blank, 0);
    check("mid_rst_hs", s_hs, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step();
    check("restart_x", s_x, 1);
    check("restart_y", s_y, 0);
    check("restart_ls", s_ls, 0);
    check("restart_fs", s_fs, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
